operand_fetch: RTL and testbench

//  Operand-collect stage between instruction decode and execute.

---
 rtl/operand_fetch.sv | 190 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch
//   Operand-collect stage sitting between instruction decode and execute.
//   The register file has a single read port, so rs1 and rs2 are read in
//   consecutive cycles (RD1 then RD2) through rf_rsel. The captured operands
//   and the decode control payload are held and presented to execute with a
//   valid/ready handshake.
//
//   Build option: define OPFETCH_FWD_EN to add a write-back bypass
//   (wb_we/wb_wa/wb_wd). With the bypass, a write-back that lands on the
//   same edge as the operand capture, to the register being read, is
//   captured in place of the register-file data, which is one cycle stale
//   at that point. Writes to x0 are never bypassed. Without the option the
//   stage captures the register-file contents as they are before that edge.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_*              decoded instruction from decode (valid/ready)
//   rf_ra1, rf_ra2    register-file read addresses (latched rs1/rs2)
//   rf_rsel           register-file port select, 0 = ra1, 1 = ra2
//   rf_rd             register-file read data (combinational)
//   wb_*              write-back bypass (OPFETCH_FWD_EN only)
//   out_*             operands and control to execute (valid/ready)
//
// State | meaning
//   IDLE  | empty, ready to accept an instruction
//   RD1   | rf_rsel = 0, capture rs1 value into out_op1
//   RD2   | rf_rsel = 1, capture rs2 value into out_op2
//   HOLD  | out_valid = 1, operands frozen until execute takes them

module operand_fetch #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic               in_need_rs2,
  input  logic [CTRL_W-1:0]  in_ctrl,

  output logic [RADDR_W-1:0] rf_ra1,
  output logic [RADDR_W-1:0] rf_ra2,
  output logic               rf_rsel,
  input  logic [XLEN-1:0]    rf_rd,

`ifdef OPFETCH_FWD_EN
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_wa,
  input  logic [XLEN-1:0]    wb_wd,
`endif

  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_op1,
  output logic [XLEN-1:0]    out_op2,
  output logic [CTRL_W-1:0]  out_ctrl
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic [RADDR_W-1:0]   rs1_q,      rs1_d;
  logic [RADDR_W-1:0]   rs2_q,      rs2_d;
  logic                 need_rs2_q, need_rs2_d;
  logic [CTRL_W-1:0]    ctrl_q,     ctrl_d;
  logic [XLEN-1:0]      op1_q,      op1_d;
  logic [XLEN-1:0]      op2_q,      op2_d;
  logic                 valid_q,    valid_d;
  logic                 rsel_q,     rsel_d;

  logic                 accept;
  logic [XLEN-1:0]      capture_data;

  // In HOLD the slot frees up on the same edge that execute takes the
  // operands, so a waiting instruction is accepted with no bubble.
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef OPFETCH_FWD_EN
  logic [RADDR_W-1:0]   read_idx;
  logic                 fwd_hit;

  assign read_idx     = (state_q == S_RD2) ? rs2_q : rs1_q;
  assign fwd_hit      = wb_we & (wb_wa != '0) & (wb_wa == read_idx);
  assign capture_data = fwd_hit ? wb_wd : rf_rd;
`else
  assign capture_data = rf_rd;
`endif

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    need_rs2_d = need_rs2_q;
    ctrl_d     = ctrl_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    valid_d    = valid_q;
    rsel_d     = 1'b0;

    // Instruction fields are latched on any handshake, from IDLE or HOLD.
    if (accept) begin
      rs1_d      = in_rs1;
      rs2_d      = in_rs2;
      need_rs2_d = in_need_rs2;
      ctrl_d     = in_ctrl;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RD1;
        end
      end

      S_RD1: begin
        op1_d = capture_data;
        if (need_rs2_q) begin
          state_d = S_RD2;
          rsel_d  = 1'b1;
        end else begin
          // Single-source instructions present a zero second operand.
          state_d = S_HOLD;
          op2_d   = '0;
          valid_d = 1'b1;
        end
      end

      S_RD2: begin
        op2_d   = capture_data;
        state_d = S_HOLD;
        valid_d = 1'b1;
      end

      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = accept ? S_RD1 : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      need_rs2_q <= 1'b0;
      ctrl_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      valid_q    <= 1'b0;
      rsel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      need_rs2_q <= need_rs2_d;
      ctrl_q     <= ctrl_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      valid_q    <= valid_d;
      rsel_q     <= rsel_d;
    end
  end

  assign rf_ra1    = rs1_q;
  assign rf_ra2    = rs2_q;
  assign rf_rsel   = rsel_q;
  assign out_valid = valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed cases (reset, two-read and one-read
// timing, hold stability, back-to-back acceptance, same-edge write-back)
// followed by randomized traffic under random backpressure. The register
// file is modelled in the bench; expected operands are taken from it when
// an instruction is handed over and checked by a separate monitor.

module tb_operand_fetch;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CTRL_W  = 16;

  typedef struct {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [RADDR_W-1:0] in_rs1 = '0;
  logic [RADDR_W-1:0] in_rs2 = '0;
  logic               in_need_rs2 = 1'b0;
  logic [CTRL_W-1:0]  in_ctrl = '0;
  logic [RADDR_W-1:0] rf_ra1;
  logic [RADDR_W-1:0] rf_ra2;
  logic               rf_rsel;
  logic [XLEN-1:0]    rf_rd;
  logic               wb_we = 1'b0;
  logic [RADDR_W-1:0] wb_wa = '0;
  logic [XLEN-1:0]    wb_wd = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [XLEN-1:0]    out_op1;
  logic [XLEN-1:0]    out_op2;
  logic [CTRL_W-1:0]  out_ctrl;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   rand_bp = 1'b0;
  exp_t sb_q[$];

  logic [XLEN-1:0]    rf [32];
  logic [RADDR_W-1:0] rf_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand_fetch #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_need_rs2(in_need_rs2), .in_ctrl(in_ctrl),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rsel(rf_rsel), .rf_rd(rf_rd),
`ifdef OPFETCH_FWD_EN
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
    .out_op2(out_op2), .out_ctrl(out_ctrl)
  );

  // Register file model: x0 reads 0, writes land at the clock edge.
  assign rf_idx = rf_rsel ? rf_ra2 : rf_ra1;
  assign rf_rd  = (rf_idx == '0) ? '0 : rf[rf_idx];
  always @(posedge clk) if (wb_we && wb_wa != '0) rf[wb_wa] <= wb_wd;

  function automatic logic [XLEN-1:0] rf_val(input logic [RADDR_W-1:0] idx);
    return (idx == '0) ? '0 : rf[idx];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random backpressure when enabled.
  always @(negedge clk) if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);

  // Monitor: pops one expectation per output handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'(out_op1), 64'hDEAD_0000);
      end else begin
        e = sb_q.pop_front();
        check("op1", 64'(out_op1), 64'(e.op1));
        check("op2", 64'(out_op2), 64'(e.op2));
        check("ctrl", 64'(out_ctrl), 64'(e.ctrl));
      end
    end
  end

  task automatic issue(input logic [RADDR_W-1:0] r1, input logic [RADDR_W-1:0] r2,
                       input logic nd, input logic [CTRL_W-1:0] c,
                       input bit ovr, input logic [XLEN-1:0] ovr_op1);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_need_rs2 = nd; in_ctrl = c;
    #1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("issue_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.op1  = ovr ? ovr_op1 : rf_val(r1);
    e.op2  = nd ? rf_val(r2) : '0;
    e.ctrl = c;
    sb_q.push_back(e);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    logic [RADDR_W-1:0] r1, r2;

    // Register file initialisation through the write port while in reset.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wb_we = 1'b1;
      wb_wa = RADDR_W'(i);
      wb_wd = (i == 5) ? 32'h11 : (i == 6) ? 32'h22 : (i == 7) ? 32'h1234 : $urandom;
    end
    @(negedge clk);
    wb_we = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", {rf_ra1, rf_ra2, rf_rsel, out_op1, out_ctrl}, 64'd0);
    check("rst_op2", 64'(out_op2), 64'd0);
    rst_n = 1'b1;

    // Reset asserted in RD2 of a two-read instruction.
    out_ready = 1'b0;
    issue(5'd5, 5'd6, 1'b1, 16'hBEEF, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_rsel", 64'(rf_rsel), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_outputs", {rf_ra1, rf_ra2, rf_rsel, out_ctrl}, 64'd0);
    check("async_rst_ops", {out_op1, out_op2}, 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Two reads: rsel 0 then 1, valid two edges after accept.
    issue(5'd5, 5'd6, 1'b1, 16'h1357, 1'b0, '0);
    @(negedge clk);
    check("rd1_rsel", 64'(rf_rsel), 64'd0);
    check("rd1_valid", 64'(out_valid), 64'd0);
    check("rd1_ra1", 64'(rf_ra1), 64'd5);
    @(negedge clk);
    check("rd2_rsel", 64'(rf_rsel), 64'd1);
    check("rd2_valid", 64'(out_valid), 64'd0);
    check("rd2_ra2", 64'(rf_ra2), 64'd6);
    // Held with out_ready low for five cycles.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ops", {out_op1, out_op2}, {32'h11, 32'h22});
      check("hold_ctrl", 64'(out_ctrl), 64'h1357);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_rsel", 64'(rf_rsel), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drain();

    // One read: valid one edge after accept, op2 zero, rsel stays 0.
    issue(5'd5, 5'd9, 1'b0, 16'h00A5, 1'b0, '0);
    @(negedge clk);
    check("one_rd1_rsel", 64'(rf_rsel), 64'd0);
    check("one_rd1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("one_valid", 64'(out_valid), 64'd1);
    check("one_rsel", 64'(rf_rsel), 64'd0);
    check("one_op2", 64'(out_op2), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    drain();

    // Back-to-back with out_ready high: next accept in the HOLD cycle.
    issue(5'd3, 5'd4, 1'b0, 16'h0001, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      prev = acc_cyc;
      issue(5'(k + 8), 5'd4, 1'b0, 16'(k + 2), 1'b0, '0);
      check("b2b_gap_one_read", 64'(acc_cyc - prev), 64'd2);
    end
    for (int k = 0; k < 3; k++) begin
      prev = acc_cyc;
      issue(5'(k + 12), 5'(k + 20), 1'b1, 16'(k + 16), 1'b0, '0);
      check("b2b_gap_two_read", 64'(acc_cyc - prev), 64'(k == 0 ? 2 : 3));
    end
    drain();

    // Write-back to x7 on the RD1 capture edge.
`ifdef OPFETCH_FWD_EN
    issue(5'd7, 5'd0, 1'b0, 16'h0777, 1'b1, 32'hABCD);
`else
    issue(5'd7, 5'd0, 1'b0, 16'h0777, 1'b1, 32'h1234);
`endif
    @(negedge clk);
    wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'hABCD;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    drain();
    check("x7_written", 64'(rf_val(5'd7)), 64'hABCD);

    // Same-edge write to x0 is never seen.
    issue(5'd0, 5'd0, 1'b0, 16'h0000, 1'b0, '0);
    @(negedge clk);
    wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    drain();

    // Randomized traffic with random backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      issue(r1, r2, 1'($urandom), 16'($urandom), 1'b0, '0);
    end
    drain();
    rand_bp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
